// File: rtl/video_stream_pkg.sv
// Shared types for the RGB444 Avalon-ST pixel stream.
// Image defaults, beat bundle, source FSM states, test-pattern helper.
package video_stream_pkg;

    localparam int DEF_IMAGE_WIDTH  = 320;
    localparam int DEF_IMAGE_HEIGHT = 240;
    localparam int RGB444_W         = 12;

    typedef logic [RGB444_W-1:0] rgb444_t;

    typedef struct packed {
        logic    sop;
        logic    eop;
        rgb444_t data;
    } stream_beat_t;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        DONE
    } src_state_e;

    function automatic rgb444_t pattern_pixel(
        input logic [7:0] x,
        input logic [7:0] y
    );
        return {x[7:4], y[7:4], x[3:0] ^ y[3:0]};
    endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry beat FIFO; the head entry is a register that drives the
// stream outputs directly, so valid/data never see ready combinationally.
module stream_skid_fifo
    import video_stream_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  stream_beat_t push_beat,
    input  logic         pop,
    output stream_beat_t head,
    output logic         head_valid,
    output logic [1:0]   count
);

    stream_beat_t tail;
    logic         pop_ok;

    assign pop_ok     = pop & (count != 2'd0);
    assign head_valid = (count != 2'd0);

    // Shift tail into head on pop; a new beat lands in the first free slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            unique case ({push, pop_ok})
                2'b10: begin
                    if (count == 2'd0) begin
                        head  <= push_beat;
                        count <= 2'd1;
                    end else if (count == 2'd1) begin
                        tail  <= push_beat;
                        count <= 2'd2;
                    end
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= push_beat;
                    end else begin
                        head <= tail;
                        tail <= push_beat;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/frame_stream_source.sv
// Reads a stored frame from pixel RAM and sends it as one sop/eop packet.
// Optional FRAME_TEST_PATTERN_EN adds a test_pattern input (x/y pattern).
module frame_stream_source
    import video_stream_pkg::*;
#(
    parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
    parameter int DATA_W       = 12,
    parameter int ADDR_W       = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
`ifdef FRAME_TEST_PATTERN_EN
    input  logic              test_pattern,
`endif
    output logic              busy,
    output logic              frame_done,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              ready_in,
    output logic              valid_out,
    output logic              startofpacket_out,
    output logic              endofpacket_out,
    output logic [DATA_W-1:0] data_out
);

    localparam int NPIX = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int XW   = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int YW   = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam logic [XW-1:0]     X_LAST    = XW'(IMAGE_WIDTH - 1);

    src_state_e   state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic         rd_pend;
    logic         pend_sop;
    logic         pend_eop;
    logic         tp_mode;
    logic         issue;
    logic         last_rd;
    logic         pop;
    logic [2:0]   credit;
    logic [1:0]   fifo_count;
    logic         head_valid;
    stream_beat_t head;
    stream_beat_t push_beat;

`ifdef FRAME_TEST_PATTERN_EN
    rgb444_t pend_pix;
`endif

    assign pop     = head_valid & ready_in;
    assign credit  = {1'b0, fifo_count} + {2'b0, rd_pend} - {2'b0, pop};
    assign issue   = (state == STREAM) && (credit < 3'd2);
    assign last_rd = (mem_addr == LAST_ADDR);
    assign mem_rd  = issue & ~tp_mode;

    assign valid_out         = head_valid;
    assign startofpacket_out = head.sop;
    assign endofpacket_out   = head.eop;
    assign data_out          = DATA_W'(head.data);

    // Tag the returning read with its frame position before buffering.
    always_comb begin
        push_beat     = '0;
        push_beat.sop = pend_sop;
        push_beat.eop = pend_eop;
`ifdef FRAME_TEST_PATTERN_EN
        push_beat.data = tp_mode ? pend_pix : rgb444_t'(mem_rdata);
`else
        push_beat.data = rgb444_t'(mem_rdata);
`endif
    end

    // Frame sequencing plus the raster position / address counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            x          <= '0;
            y          <= '0;
            mem_addr   <= '0;
`ifdef FRAME_TEST_PATTERN_EN
            tp_mode    <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (start) begin
                        state    <= STREAM;
                        busy     <= 1'b1;
                        x        <= '0;
                        y        <= '0;
                        mem_addr <= '0;
`ifdef FRAME_TEST_PATTERN_EN
                        tp_mode  <= test_pattern;
`endif
                    end
                end
                STREAM: begin
                    if (issue) begin
                        if (last_rd) begin
                            state    <= DRAIN;
                            x        <= '0;
                            y        <= '0;
                            mem_addr <= '0;
                        end else begin
                            mem_addr <= mem_addr + 1'b1;
                            if (x == X_LAST) begin
                                x <= '0;
                                y <= y + 1'b1;
                            end else begin
                                x <= x + 1'b1;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (pop && head.eop) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef FRAME_TEST_PATTERN_EN
    assign tp_mode = 1'b0;
`endif

    // One-cycle read pipeline: remember what the outstanding read is.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend  <= 1'b0;
            pend_sop <= 1'b0;
            pend_eop <= 1'b0;
`ifdef FRAME_TEST_PATTERN_EN
            pend_pix <= '0;
`endif
        end else begin
            rd_pend  <= issue;
            pend_sop <= (mem_addr == '0);
            pend_eop <= last_rd;
`ifdef FRAME_TEST_PATTERN_EN
            pend_pix <= pattern_pixel(8'(x), 8'(y));
`endif
        end
    end

    stream_skid_fifo u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (rd_pend),
        .push_beat  (push_beat),
        .pop        (pop),
        .head       (head),
        .head_valid (head_valid),
        .count      (fifo_count)
    );

endmodule

// File: tb/tb_frame_stream_source.sv
// Bench for frame_stream_source: 8x4 frame against a RAM with mem[a]=a,
// plus a 1x1 instance; build with FRAME_TEST_PATTERN_EN for pattern mode.
module tb_frame_stream_source;

    localparam int W = 8;
    localparam int H = 4;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        ready_in = 1'b0;
    logic        busy, frame_done, mem_rd;
    logic [16:0] mem_addr;
    logic [11:0] mem_rdata = '0;
    logic        valid_out, startofpacket_out, endofpacket_out;
    logic [11:0] data_out;

    logic        start1 = 1'b0;
    logic        ready1 = 1'b1;
    logic        busy1, fd1, mem_rd1, valid1, sop1, eop1;
    logic [0:0]  mem_addr1;
    logic [11:0] mem_rdata1 = '0;
    logic [11:0] data1;

`ifdef FRAME_TEST_PATTERN_EN
    logic test_pattern = 1'b0;
    logic tp1 = 1'b0;
`endif

    always #5 clk = ~clk;

    frame_stream_source #(
        .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .DATA_W(12), .ADDR_W(17)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
`ifdef FRAME_TEST_PATTERN_EN
        .test_pattern(test_pattern),
`endif
        .busy(busy), .frame_done(frame_done), .mem_rd(mem_rd),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .ready_in(ready_in),
        .valid_out(valid_out), .startofpacket_out(startofpacket_out),
        .endofpacket_out(endofpacket_out), .data_out(data_out)
    );

    frame_stream_source #(
        .IMAGE_WIDTH(1), .IMAGE_HEIGHT(1), .DATA_W(12), .ADDR_W(1)
    ) dut1 (
        .clk(clk), .reset(reset), .start(start1),
`ifdef FRAME_TEST_PATTERN_EN
        .test_pattern(tp1),
`endif
        .busy(busy1), .frame_done(fd1), .mem_rd(mem_rd1),
        .mem_addr(mem_addr1), .mem_rdata(mem_rdata1), .ready_in(ready1),
        .valid_out(valid1), .startofpacket_out(sop1),
        .endofpacket_out(eop1), .data_out(data1)
    );

    // Synchronous pixel RAMs: mem[a] = a[11:0], one cycle read latency.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem_addr[11:0];
        if (mem_rd1) mem_rdata1 <= 12'(mem_addr1);
    end

    typedef struct {
        logic        sop;
        logic        eop;
        logic [11:0] data;
        int          cyc;
    } beat_t;

    typedef struct {
        int off;
        int busy;
        int rd;
        int valid;
        int sop;
        int eop;
        int fd;
        int data;
        int addr;
    } vec_t;

    beat_t       beats[$];
    int          fd_cyc[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          issued = 0;
    int          popped = 0;
    int          rd_total = 0;
    logic        prev_stall = 1'b0;
    logic [13:0] prev_out = '0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic int exp_pix(input int k, input bit pat);
        logic [7:0]  xb;
        logic [7:0]  yb;
        logic [11:0] v;
        if (!pat) return k & 12'hfff;
        xb = 8'(k % W);
        yb = 8'(k / W);
        v  = {xb[7:4], yb[7:4], xb[3:0] ^ yb[3:0]};
        return int'(v);
    endfunction

    // One clock cycle under the inputs already applied: watch, then advance.
    task automatic cycle();
        #1;
        if (!reset) begin
            if (prev_stall)
                chk("stall_hold",
                    int'({valid_out, startofpacket_out, endofpacket_out, data_out}),
                    int'({1'b1, prev_out}));
            issued   += int'(mem_rd);
            rd_total += int'(mem_rd);
            popped   += int'(valid_out && ready_in);
            chk("credit_le_2", int'((issued - popped) <= 2), 1);
            if (valid_out && ready_in)
                beats.push_back('{startofpacket_out, endofpacket_out, data_out, cyc});
            if (frame_done) fd_cyc.push_back(cyc);
            prev_stall = valid_out && !ready_in;
            prev_out   = {startofpacket_out, endofpacket_out, data_out};
        end else begin
            issued     = 0;
            popped     = 0;
            prev_stall = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    function automatic logic rnd(input int pct);
        return ($urandom_range(99) < pct);
    endfunction

    task automatic check_frame(input string name, input int b0, input bit pat);
        for (int k = 0; k < N; k++) begin
            if (b0 + k < beats.size()) begin
                chk({name, "_data"}, int'(beats[b0 + k].data), exp_pix(k, pat));
                chk({name, "_sop"}, int'(beats[b0 + k].sop), int'(k == 0));
                chk({name, "_eop"}, int'(beats[b0 + k].eop), int'(k == N - 1));
            end
        end
    endtask

    task automatic run_frame(input string name, input int pct, input bit pat);
        int b0;
        int f0;
        int lim;
        b0  = beats.size();
        f0  = fd_cyc.size();
        lim = 0;
`ifdef FRAME_TEST_PATTERN_EN
        test_pattern = pat;
`endif
        start    = 1'b1;
        ready_in = rnd(pct);
        cycle();
        start = 1'b0;
        while (fd_cyc.size() == f0 && lim < 3000) begin
            ready_in = rnd(pct);
            cycle();
            lim++;
        end
        chk({name, "_no_timeout"}, int'(lim < 3000), 1);
        chk({name, "_len"}, beats.size() - b0, N);
        check_frame(name, b0, pat);
        if (fd_cyc.size() > f0 && beats.size() > b0)
            chk({name, "_fd_after_eop"}, fd_cyc[f0] - beats[beats.size() - 1].cyc, 1);
    endtask

    vec_t tbl[10];

    initial begin
        int b0;
        int f0;
        int rel;
        int lim;
        int cnt;
        int fd_off;
        int rd0;

        tbl[0] = '{1, 1, 1, 0, 0, 0, 0, -1, 0};
        tbl[1] = '{2, 1, 1, 0, 0, 0, 0, -1, 1};
        tbl[2] = '{3, 1, 1, 1, 1, 0, 0, 0, 2};
        tbl[3] = '{4, 1, 1, 1, 0, 0, 0, 1, 3};
        tbl[4] = '{17, 1, 1, 1, 0, 0, 0, 14, 16};
        tbl[5] = '{32, 1, 1, 1, 0, 0, 0, 29, 31};
        tbl[6] = '{33, 1, 0, 1, 0, 0, 0, 30, -1};
        tbl[7] = '{34, 1, 0, 1, 0, 1, 0, 31, -1};
        tbl[8] = '{35, 0, 0, 0, 0, 0, 1, -1, -1};
        tbl[9] = '{36, 0, 0, 0, 0, 0, 0, -1, -1};

        @(negedge clk);
        repeat (3) cycle();
        #1;
        chk("rst_valid", int'(valid_out), 0);
        chk("rst_sop", int'(startofpacket_out), 0);
        chk("rst_eop", int'(endofpacket_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_fd", int'(frame_done), 0);
        chk("rst_mem_rd", int'(mem_rd), 0);
        chk("rst_data", int'(data_out), 0);
        chk("rst_addr", int'(mem_addr), 0);
        reset = 1'b0;
        cycle();

        // Full-throughput frame against the timing table.
        b0       = beats.size();
        ready_in = 1'b1;
        start    = 1'b1;
        cycle();
        start = 1'b0;
        rel   = 1;
        for (int i = 0; i < 10; i++) begin
            while (rel < tbl[i].off) begin
                cycle();
                rel++;
            end
            chk($sformatf("t%0d_busy", tbl[i].off), int'(busy), tbl[i].busy);
            chk($sformatf("t%0d_mem_rd", tbl[i].off), int'(mem_rd), tbl[i].rd);
            chk($sformatf("t%0d_valid", tbl[i].off), int'(valid_out), tbl[i].valid);
            chk($sformatf("t%0d_sop", tbl[i].off), int'(startofpacket_out), tbl[i].sop);
            chk($sformatf("t%0d_eop", tbl[i].off), int'(endofpacket_out), tbl[i].eop);
            chk($sformatf("t%0d_fd", tbl[i].off), int'(frame_done), tbl[i].fd);
            if (tbl[i].data >= 0)
                chk($sformatf("t%0d_data", tbl[i].off), int'(data_out), tbl[i].data);
            if (tbl[i].addr >= 0)
                chk($sformatf("t%0d_addr", tbl[i].off), int'(mem_addr), tbl[i].addr);
        end
        cycle();
        chk("full_len", beats.size() - b0, N);
        check_frame("full", b0, 1'b0);

        // Random backpressure frames.
        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(3)) cycle();
            run_frame($sformatf("rand%0d", r), (r == 1) ? 25 : 50, 1'b0);
        end

        // start held high: back-to-back frames, start ignored while busy.
        b0       = beats.size();
        f0       = fd_cyc.size();
        ready_in = 1'b1;
        start    = 1'b1;
        lim      = 0;
        cycle();
        while (fd_cyc.size() == f0 && lim < 200) begin
            chk("b2b_busy_held", int'(busy || frame_done), 1);
            cycle();
            lim++;
        end
        start = 1'b0;
        while (fd_cyc.size() < f0 + 2 && lim < 400) begin
            cycle();
            lim++;
        end
        chk("b2b_no_timeout", int'(lim < 400), 1);
        repeat (6) cycle();
        chk("b2b_frames", fd_cyc.size() - f0, 2);
        chk("b2b_len", beats.size() - b0, 2 * N);
        check_frame("b2b_f1", b0, 1'b0);
        check_frame("b2b_f2", b0 + N, 1'b0);
        if (beats.size() - b0 >= 2 * N && fd_cyc.size() - f0 >= 2) begin
            chk("b2b_sop2_gap", beats[b0 + N].cyc - fd_cyc[f0], 3);
            chk("b2b_fd2", fd_cyc[f0 + 1] - beats[b0 + 2 * N - 1].cyc, 1);
        end
        chk("b2b_idle_after", int'(busy), 0);

        // Reset while beat 10 is on the bus.
        b0       = beats.size();
        ready_in = 1'b1;
        start    = 1'b1;
        cycle();
        start = 1'b0;
        lim   = 0;
        while (!(valid_out && data_out == 12'd10) && lim < 100) begin
            cycle();
            lim++;
        end
        chk("rst_mid_found_beat10", int'(lim < 100), 1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        #1;
        chk("rst_mid_valid", int'(valid_out), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_beats", beats.size() - b0, 10);
        cycle();
        run_frame("after_reset", 100, 1'b0);

`ifdef FRAME_TEST_PATTERN_EN
        rd0 = rd_total;
        run_frame("pattern", 60, 1'b1);
        chk("pattern_no_mem_rd", rd_total - rd0, 0);
        b0 = beats.size() - N + 2 * W + 3;
        chk("pattern_x3y2", int'(beats[b0].data), exp_pix(2 * W + 3, 1'b1));
`else
        rd0 = 0;
`endif

        // 1x1 frame on the second instance.
        start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        cnt    = 0;
        fd_off = -1;
        for (int o = 1; o <= 8; o++) begin
            #1;
            if (valid1) begin
                cnt++;
                chk("one_sop", int'(sop1), 1);
                chk("one_eop", int'(eop1), 1);
                chk("one_data", int'(data1), 0);
                chk("one_offset", o, 3);
            end
            if (fd1) fd_off = o;
            @(posedge clk);
            @(negedge clk);
        end
        chk("one_count", cnt, 1);
        chk("one_fd_offset", fd_off, 4);
        chk("one_idle", int'(busy1), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
